// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants and stack-op encoding
package core_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int STACK_DEPTH = 16;

    // Encoding is {push, pop}, so a stack op is just those two strobes.
    typedef enum logic [1:0] {
        NONE    = 2'b00,
        POP     = 2'b01,
        PUSH    = 2'b10,
        REPLACE = 2'b11
    } stack_op_t;

    function automatic stack_op_t decode_stack_op(input logic push, input logic pop);
        return stack_op_t'({push, pop});
    endfunction

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - depth x width single-write, async-read stack storage
module stack_ram #(
    parameter int width     = 16,
    parameter int depth     = 16,
    parameter int ptr_width = $clog2(depth)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ptr_width-1:0] wr_addr,
    input  logic [width-1:0]     wr_data,
    input  logic [ptr_width-1:0] rd_addr,
    output logic [width-1:0]     rd_data
);

    logic [width-1:0] mem [depth];

    // Contents are deliberately not reset so this maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/data_stack.sv
// rtl/data_stack.sv - parameter stack below TOS; DATA_STACK_GUARD_EN enables overflow/underflow guarding
module data_stack
    import core_pkg::*;
#(
    parameter int width     = DATA_WIDTH,
    parameter int depth     = STACK_DEPTH,
    parameter int ptr_width = $clog2(depth)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wait_state,
    input  logic                 push,
    input  logic                 pop,
    input  logic [width-1:0]     push_data,
    output logic [width-1:0]     pstack_top,
    output logic [ptr_width:0]   count,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow,
    output logic                 underflow
);

`ifdef DATA_STACK_GUARD_EN
    localparam bit guard_en = 1'b1;
`else
    localparam bit guard_en = 1'b0;
`endif

    localparam logic [ptr_width:0]   cap     = (ptr_width+1)'(depth + 1);
    localparam logic [ptr_width:0]   cnt_one = (ptr_width+1)'(1);
    localparam logic [ptr_width-1:0] ptr_one = ptr_width'(1);

    stack_op_t              op;
    logic [width-1:0]       nos_r, nos_next, ram_rd_data;
    logic [ptr_width-1:0]   wr_ptr, wr_ptr_next, rd_ptr;
    logic [ptr_width:0]     count_r, count_next;
    logic                   ram_we, ram_we_next, ovf_set, unf_set;

    assign op     = decode_stack_op(push, pop);
    assign rd_ptr = wr_ptr - ptr_one;
    assign empty  = (count_r == '0);
    assign full   = (count_r == cap);

    always_comb begin
        nos_next    = nos_r;
        wr_ptr_next = wr_ptr;
        count_next  = count_r;
        ram_we_next = 1'b0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
        if (!wait_state) begin
            case (op)
                PUSH: begin
                    if (guard_en && full) begin
                        ovf_set = 1'b1;
                    end else begin
                        ram_we_next = 1'b1;
                        nos_next    = push_data;
                        wr_ptr_next = wr_ptr + ptr_one;
                        if (!full) count_next = count_r + cnt_one;
                    end
                end
                POP: begin
                    if (guard_en && empty) begin
                        unf_set = 1'b1;
                    end else begin
                        nos_next    = ram_rd_data;
                        wr_ptr_next = wr_ptr - ptr_one;
                        if (!empty) count_next = count_r - cnt_one;
                    end
                end
                REPLACE: begin
                    if (guard_en && empty) unf_set = 1'b1;
                    else nos_next = push_data;
                end
                default: ;
            endcase
        end
    end

    // Reset must also block the spill, since it wins over a concurrent push.
    assign ram_we = ram_we_next && !reset;

    stack_ram #(
        .width     (width),
        .depth     (depth),
        .ptr_width (ptr_width)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (wr_ptr),
        .wr_data (nos_r),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            nos_r   <= '0;
            wr_ptr  <= '0;
            count_r <= '0;
        end else begin
            nos_r   <= nos_next;
            wr_ptr  <= wr_ptr_next;
            count_r <= count_next;
        end
    end

`ifdef DATA_STACK_GUARD_EN
    logic ovf_r, unf_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (ovf_set) ovf_r <= 1'b1;
            if (unf_set) unf_r <= 1'b1;
        end
    end

    assign overflow  = ovf_r;
    assign underflow = unf_r;
`else
    logic unused_flag_sets;
    assign unused_flag_sets = ovf_set | unf_set;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign pstack_top = nos_r;
    assign count      = count_r;

endmodule

// File: tb/tb_data_stack.sv
// tb/tb_data_stack.sv - scoreboard bench for data_stack (either DATA_STACK_GUARD_EN build)
module tb_data_stack;

`ifdef DATA_STACK_GUARD_EN
    localparam bit G = 1'b1;
`else
    localparam bit G = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, wait_state, push, pop;
    logic [15:0] push_data, pstack_top;
    logic [4:0]  count;
    logic        empty, full, overflow, underflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [15:0] top;
        logic [4:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb[$];

    data_stack dut (
        .clk        (clk),
        .reset      (reset),
        .wait_state (wait_state),
        .push       (push),
        .pop        (pop),
        .push_data  (push_data),
        .pstack_top (pstack_top),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic ps, input logic pp,
                        input logic [15:0] d, input logic [15:0] et, input logic [4:0] ec,
                        input logic eo, input logic eu, input string tag);
        exp_t e;
        reset = r; wait_state = w; push = ps; pop = pp; push_data = d;
        e.tag = tag; e.top = et; e.cnt = ec; e.ovf = eo; e.unf = eu;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".top"},   32'(pstack_top), 32'(e.top));
        chk({e.tag, ".count"}, 32'(count),      32'(e.cnt));
        chk({e.tag, ".empty"}, 32'(empty),      32'(e.cnt == 5'd0));
        chk({e.tag, ".full"},  32'(full),       32'(e.cnt == 5'd17));
        chk({e.tag, ".ovf"},   32'(overflow),   32'(e.ovf));
        chk({e.tag, ".unf"},   32'(underflow),  32'(e.unf));
    endtask

    initial begin
        reset = 1'b1; wait_state = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
        #1;
        step(1, 0, 0, 0, 16'h0000, 16'h0000, 5'd0, 0, 0, "reset");
        step(1, 1, 1, 0, 16'h9999, 16'h0000, 5'd0, 0, 0, "reset_over_wait");

        step(0, 0, 1, 0, 16'h1111, 16'h1111, 5'd1, 0, 0, "push1");
        step(0, 0, 1, 0, 16'h2222, 16'h2222, 5'd2, 0, 0, "push2");
        step(0, 0, 1, 0, 16'h3333, 16'h3333, 5'd3, 0, 0, "push3");
        step(0, 0, 0, 0, 16'h0000, 16'h3333, 5'd3, 0, 0, "hold");
        step(0, 0, 0, 1, 16'h0000, 16'h2222, 5'd2, 0, 0, "pop1");
        step(0, 0, 0, 1, 16'h0000, 16'h1111, 5'd1, 0, 0, "pop2");
        step(0, 0, 0, 1, 16'h0000, 16'h0000, 5'd0, 0, 0, "pop3");

        step(0, 0, 1, 0, 16'hAAAA, 16'hAAAA, 5'd1, 0, 0, "pushA");
        step(0, 0, 1, 0, 16'hBEEF, 16'hBEEF, 5'd2, 0, 0, "pushB");
        step(0, 0, 1, 1, 16'hCAFE, 16'hCAFE, 5'd2, 0, 0, "replace");
        step(0, 0, 0, 1, 16'h0000, 16'hAAAA, 5'd1, 0, 0, "pop_after_rep");
        step(0, 0, 0, 1, 16'h0000, 16'h0000, 5'd0, 0, 0, "pop_to_empty");

        for (int i = 0; i < 3; i++)
            step(0, 1, 1, 0, 16'h5A5A, 16'h0000, 5'd0, 0, 0, $sformatf("wait%0d", i));
        step(0, 0, 1, 0, 16'h5A5A, 16'h5A5A, 5'd1, 0, 0, "wait_release");
        step(0, 0, 0, 0, 16'h5A5A, 16'h5A5A, 5'd1, 0, 0, "single_push");

        step(1, 0, 0, 0, 16'h0000, 16'h0000, 5'd0, 0, 0, "reset2");
        for (int i = 1; i <= 17; i++)
            step(0, 0, 1, 0, 16'(i), 16'(i), 5'(i), 0, 0, $sformatf("fill%0d", i));
        step(0, 0, 1, 0, 16'h00FF, G ? 16'd17 : 16'h00FF, 5'd17, G, 0, "push_full");
        for (int j = 1; j <= 16; j++)
            step(0, 0, 0, 1, 16'h0000, G ? 16'(17 - j) : 16'(18 - j), 5'(17 - j), G, 0,
                 $sformatf("drain%0d", j));

        step(1, 0, 0, 0, 16'h0000, 16'h0000, 5'd0, 0, 0, "reset3");
        step(0, 0, 0, 1, 16'h0000, G ? 16'h0000 : 16'h000F, 5'd0, 0, G, "pop_empty");
        step(0, 0, 1, 1, 16'h1234, G ? 16'h0000 : 16'h1234, 5'd0, 0, G, "replace_empty");
        step(1, 0, 1, 0, 16'h7777, 16'h0000, 5'd0, 0, 0, "reset_with_push");
        step(0, 0, 1, 0, 16'h4242, 16'h4242, 5'd1, 0, 0, "push_after_reset");

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
